// File: rtl/full_adder_bist.sv
// full_adder_bist: built-in self test that sweeps all eight full-adder vectors and scores the responses
module full_adder_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_cin,
  input  logic       dut_s,
  input  logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail
);
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
  localparam logic [3:0] SETTLE_W = 4'(SETTLE);
  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d, first_q, first_d;
  logic [3:0] cnt_q, cnt_d, err_q, err_d;
  logic       fv_q, fv_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic       exp_s, exp_c, sample, miss;
  // the drive pins come straight from the vector register, so they stay registered and hold 111 in DONE
  assign dut_a      = vec_q[2];
  assign dut_b      = vec_q[1];
  assign dut_cin    = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = first_q;
  assign exp_s      = ^vec_q;
  assign exp_c      = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
  assign sample     = (state_q == HOLD) && (cnt_q == SETTLE_W);
  assign miss       = sample && ({dut_s, dut_c} != {exp_s, exp_c});
  // next-state: start (re)arms from IDLE/DONE; HOLD waits SETTLE cycles, scores, then steps or finishes
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    first_d = first_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (state_q != HOLD && start) begin
      state_d = HOLD;
      vec_d   = 3'd0;
      cnt_d   = 4'd0;
      err_d   = 4'd0;
      fv_d    = 1'b0;
      first_d = 3'd0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q + 4'd1;
      if (sample) begin
        cnt_d = 4'd0;
        if (miss) begin
          err_d = err_q + 4'd1;
          if (!fv_q) begin
            fv_d    = 1'b1;
            first_d = vec_q;
          end
        end
        if (vec_q == 3'd7) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end else begin
          vec_d = vec_q + 3'd1;
        end
      end
    end
  end
  // state and result registers; reset aborts any run and discards partial results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      fv_q    <= 1'b0;
      first_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
endmodule

// File: tb/tb_full_adder_bist.sv
// tb_full_adder_bist: scoreboard bench driving the BIST against correct and faulty full-adder models
module tb_full_adder_bist;
  typedef struct packed {
    logic [3:0] err;
    logic [2:0] first;
    logic       fv;
    logic       pass;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode = 0;
  int   errors = 0;
  int   checks = 0;
  res_t sb[$];
  logic       a1, b1, cin1, s1, c1, busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [2:0] ff1;
  logic       a0, b0, cin0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [2:0] ff0;
  logic       a3, b3, cin3, busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [2:0] ff3;
  always #5 clk = ~clk;
  assign s1 = (mode == 2) ? ~(a1 ^ b1 ^ cin1) : (a1 ^ b1 ^ cin1);
  assign c1 = (mode == 1) ? 1'b0 : ((a1 & b1) | (a1 & cin1) | (b1 & cin1));
  full_adder_bist #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a1), .dut_b(b1), .dut_cin(cin1),
    .dut_s(s1), .dut_c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .first_fail(ff1));
  full_adder_bist #(.SETTLE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a0), .dut_b(b0), .dut_cin(cin0),
    .dut_s(a0 ^ b0 ^ cin0), .dut_c((a0 & b0) | (a0 & cin0) | (b0 & cin0)),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fv0), .first_fail(ff0));
  full_adder_bist #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a3), .dut_b(b3), .dut_cin(cin3),
    .dut_s(a3 ^ b3 ^ cin3), .dut_c((a3 & b3) | (a3 & cin3) | (b3 & cin3)),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_valid(fv3), .first_fail(ff3));
  function automatic res_t model(input int m);
    res_t r = '0;
    for (int v = 0; v < 8; v++) begin
      logic a = v[2], b = v[1], ci = v[0];
      logic rs = a ^ b ^ ci;
      logic rc = (a & b) | (a & ci) | (b & ci);
      logic fs = (m == 2) ? ~rs : rs;
      logic fc = (m == 1) ? 1'b0 : rc;
      if ({fs, fc} != {rs, rc}) begin
        if (!r.fv) r.first = 3'(v);
        r.fv  = 1'b1;
        r.err = r.err + 4'd1;
      end
    end
    r.pass = (r.err == 4'd0);
    return r;
  endfunction
  task automatic test_reset();
    #2;
    checks++;
    if ({a1, b1, cin1, busy1, done1, pass1, err1, fv1, ff1} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got %b want 0", {a1, b1, cin1, busy1, done1, pass1, err1, fv1, ff1});
    end
    rst_n = 1'b1;
  endtask
  task automatic run_u1(input int m, input bit poke);
    res_t exp, got;
    sb.push_back(model(m));
    mode = m;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (busy1 !== (i < 16) || done1 !== (i == 16)) begin
        errors++;
        $display("FAIL busy_done m=%0d cyc=%0d: got busy=%b done=%b want busy=%b done=%b", m, i, busy1, done1, i < 16, i == 16);
      end
      checks++;
      if ({a1, b1, cin1} !== ((i < 16) ? 3'(i / 2) : 3'd7)) begin
        errors++;
        $display("FAIL drive_vec m=%0d cyc=%0d: got %b want %b", m, i, {a1, b1, cin1}, (i < 16) ? 3'(i / 2) : 3'd7);
      end
      if (i == 0) begin
        checks++;
        if ({err1, fv1, ff1, pass1} !== 9'd0) begin
          errors++;
          $display("FAIL clear_on_start m=%0d: got err=%0d fv=%b ff=%0d pass=%b want all 0", m, err1, fv1, ff1, pass1);
        end
      end
      start = poke && (i == 5);
    end
    start = 1'b0;
    exp = sb.pop_front();
    got = '{err: err1, first: ff1, fv: fv1, pass: pass1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL result m=%0d: got err=%0d first=%0d fv=%b pass=%b want err=%0d first=%0d fv=%b pass=%b",
               m, got.err, got.first, got.fv, got.pass, exp.err, exp.first, exp.fv, exp.pass);
    end
  endtask
  task automatic test_faults();
    run_u1(0, 1'b0);
    run_u1(1, 1'b0);
    run_u1(2, 1'b0);
  endtask
  task automatic test_back_to_back();
    run_u1(1, 1'b1);
    run_u1(1, 1'b0);
  endtask
  task automatic test_reset_mid_run();
    mode = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({a1, b1, cin1, busy1, done1, pass1, err1, fv1, ff1} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got %b want 0", {a1, b1, cin1, busy1, done1, pass1, err1, fv1, ff1});
    end
    #2 rst_n = 1'b1;
    run_u1(0, 1'b0);
  endtask
  task automatic test_settle();
    int t0 = -1, t3 = -1;
    repeat (40) @(posedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done0 && t0 < 0) t0 = i;
      if (done3 && t3 < 0) t3 = i;
    end
    checks++;
    if (t0 != 8 || !pass0 || err0 !== 4'd0) begin
      errors++;
      $display("FAIL settle0: got done_at=%0d pass=%b err=%0d want done_at=8 pass=1 err=0", t0, pass0, err0);
    end
    checks++;
    if (t3 != 32 || !pass3 || fv3 !== 1'b0) begin
      errors++;
      $display("FAIL settle3: got done_at=%0d pass=%b fv=%b want done_at=32 pass=1 fv=0", t3, pass3, fv3);
    end
  endtask
  initial begin
    test_reset();
    test_faults();
    test_back_to_back();
    test_reset_mid_run();
    test_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
